// File: rtl/pipe_ctrl_seq.sv
// Pipeline control sequencer for the 5-stage core.
// Turns hazard-unit stall/flush requests and data-memory busy into per-stage register
// enables and bubble flushes. A redirect adds a second IF/ID flush cycle because the
// instruction memory read is synchronous. It also keeps saturating performance counters
// and a sticky memory-timeout watchdog.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   stall_i, flush_i, mem_busy_i load-use stall, Execute redirect, data memory busy
//   en_{f,d,e,m,w}_o             per-stage register enables
//   flush_d_o, flush_e_o         clear IF/ID and ID/EX to a bubble
//   state_o                      0 RUN, 1 REDIRECT, 2 FREEZE
//   stall_cycles_o, flush_events_o, freeze_cycles_o   saturating event counters
//   mem_timeout_o                sticky watchdog flag
module pipe_ctrl_seq #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_busy_i,
    output logic             en_f_o,
    output logic             en_d_o,
    output logic             en_e_o,
    output logic             en_m_o,
    output logic             en_w_o,
    output logic             flush_d_o,
    output logic             flush_e_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] freeze_cycles_o,
    output logic             mem_timeout_o
);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StRedirect = 2'd1,
        StFreeze   = 2'd2,
        StIllegal  = 2'd3
    } state_e;

    localparam logic [15:0]      TimeoutVal = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    state_e           r_state, w_state_d;
    logic             r_pend_redir, w_pend_redir_d;
    logic [15:0]      r_busy_run, w_busy_run_d;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_freeze_cnt;
    logic             r_timeout;

    logic w_en_fd, w_en_emw, w_flush_d, w_flush_e;
    logic w_inc_stall, w_inc_flush, w_inc_freeze;

    always_comb begin
        w_en_fd        = 1'b1;
        w_en_emw       = 1'b1;
        w_flush_d      = 1'b0;
        w_flush_e      = 1'b0;
        w_state_d      = StRun;
        w_pend_redir_d = r_pend_redir;
        w_inc_stall    = 1'b0;
        w_inc_flush    = 1'b0;
        w_inc_freeze   = 1'b0;

        if (mem_busy_i) begin
            w_en_fd      = 1'b0;
            w_en_emw     = 1'b0;
            w_state_d    = StFreeze;
            w_inc_freeze = 1'b1;
            // Remember an interrupted redirect tail so it is replayed on release.
            if (r_state == StRedirect) begin
                w_pend_redir_d = 1'b1;
            end
        end else begin
            w_pend_redir_d = 1'b0;
            if (r_state == StFreeze && r_pend_redir && !flush_i) begin
                w_flush_d = 1'b1;
            end else if (flush_i) begin
                w_flush_d   = 1'b1;
                w_flush_e   = 1'b1;
                w_state_d   = StRedirect;
                w_inc_flush = 1'b1;
            end else if (r_state == StRedirect) begin
                // Second fetch flush: squash the instruction fetched from the stale PC.
                w_flush_d = 1'b1;
            end else if (stall_i) begin
                w_en_fd     = 1'b0;
                w_flush_e   = 1'b1;
                w_inc_stall = 1'b1;
            end
        end

        if (r_state == StIllegal) begin
            w_state_d = StRun;
        end
    end

    always_comb begin
        w_busy_run_d = 16'd0;
        if (mem_busy_i) begin
            w_busy_run_d = (r_busy_run == TimeoutVal) ? r_busy_run : r_busy_run + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StRun;
            r_pend_redir <= 1'b0;
            r_busy_run   <= 16'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pend_redir <= w_pend_redir_d;
            r_busy_run   <= w_busy_run_d;
            if (w_inc_stall && r_stall_cnt != CntMax) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_inc_flush && r_flush_cnt != CntMax) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
            if (w_inc_freeze && r_freeze_cnt != CntMax) begin
                r_freeze_cnt <= r_freeze_cnt + 1'b1;
            end
            if (w_busy_run_d == TimeoutVal) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Outputs are forced to the safe bubble pattern while reset is held.
    assign en_f_o          = rst_n & w_en_fd;
    assign en_d_o          = rst_n & w_en_fd;
    assign en_e_o          = rst_n & w_en_emw;
    assign en_m_o          = rst_n & w_en_emw;
    assign en_w_o          = rst_n & w_en_emw;
    assign flush_d_o       = ~rst_n | w_flush_d;
    assign flush_e_o       = ~rst_n | w_flush_e;
    assign state_o         = r_state;
    assign stall_cycles_o  = r_stall_cnt;
    assign flush_events_o  = r_flush_cnt;
    assign freeze_cycles_o = r_freeze_cnt;
    assign mem_timeout_o   = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl_seq.sv
// Scoreboard bench for pipe_ctrl_seq (CNT_W=3 to reach counter saturation, TIMEOUT=4).
// Each step drives one cycle of inputs and queues the hand-computed outputs for that
// cycle; the monitor samples the DUT on the falling edge and compares.
module tb_pipe_ctrl_seq;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          mem_busy_i = 1'b0;
    logic          en_f_o, en_d_o, en_e_o, en_m_o, en_w_o;
    logic          flush_d_o, flush_e_o;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cycles_o, flush_events_o, freeze_cycles_o;
    logic          mem_timeout_o;

    pipe_ctrl_seq #(.CNT_W(CW), .TIMEOUT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .mem_busy_i      (mem_busy_i),
        .en_f_o          (en_f_o),
        .en_d_o          (en_d_o),
        .en_e_o          (en_e_o),
        .en_m_o          (en_m_o),
        .en_w_o          (en_w_o),
        .flush_d_o       (flush_d_o),
        .flush_e_o       (flush_e_o),
        .state_o         (state_o),
        .stall_cycles_o  (stall_cycles_o),
        .flush_events_o  (flush_events_o),
        .freeze_cycles_o (freeze_cycles_o),
        .mem_timeout_o   (mem_timeout_o)
    );

    always #5 clk = ~clk;

    // {en_f,en_d,en_e,en_m,en_w, flush_d, flush_e, state, stall_cnt, flush_cnt, freeze_cnt, timeout}
    typedef logic [18:0] exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam logic [4:0] EnAll  = 5'b11111;
    localparam logic [4:0] EnNone = 5'b00000;
    localparam logic [4:0] EnLu   = 5'b00111;

    task automatic step(input string nm, input logic rst, input logic s, input logic f,
                        input logic b, input logic [4:0] en, input logic fd, input logic fe,
                        input logic [1:0] st, input int sc, input int fc, input int zc,
                        input logic to);
        @(posedge clk);
        #1;
        rst_n      = rst;
        stall_i    = s;
        flush_i    = f;
        mem_busy_i = b;
        exp_q.push_back({en, fd, fe, st, 3'(sc), 3'(fc), 3'(zc), to});
        name_q.push_back(nm);
    endtask

    task automatic do_reset(input string nm);
        step(nm, 1'b0, 1'b0, 1'b0, 1'b0, EnNone, 1'b1, 1'b1, 2'd0, 0, 0, 0, 1'b0);
    endtask

    exp_t  m_exp, m_act;
    string m_name;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_name = name_q.pop_front();
            m_act  = {en_f_o, en_d_o, en_e_o, en_m_o, en_w_o, flush_d_o, flush_e_o, state_o,
                      stall_cycles_o, flush_events_o, freeze_cycles_o, mem_timeout_o};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL %s @%0t: got %b expected %b", m_name, $time, m_act, m_exp);
            end
        end
    end

    initial begin
        // Reset mid-freeze (5 busy cycles also trip the TIMEOUT=4 watchdog)
        do_reset("reset0");
        step("frz1", 1, 0, 0, 1, EnNone, 0, 0, 2'd0, 0, 0, 0, 0);
        step("frz2", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 1, 0);
        step("frz3", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 2, 0);
        step("frz4", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 3, 0);
        step("frz5", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 4, 1);
        step("rst_mid_freeze", 0, 0, 0, 1, EnNone, 1, 1, 2'd0, 0, 0, 0, 0);
        step("post_reset_idle", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 0, 0, 0, 0);

        // Load-use then redirect
        step("loaduse", 1, 1, 0, 0, EnLu, 0, 1, 2'd0, 0, 0, 0, 0);
        step("loaduse_after", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 1, 0, 0, 0);
        step("redir_c0", 1, 0, 1, 0, EnAll, 1, 1, 2'd0, 1, 0, 0, 0);
        step("redir_c1", 1, 0, 0, 0, EnAll, 1, 0, 2'd1, 1, 1, 0, 0);
        step("redir_c2", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 1, 1, 0, 0);

        // Simultaneous flush+stall+busy
        do_reset("reset1");
        step("sim_frz1", 1, 1, 1, 1, EnNone, 0, 0, 2'd0, 0, 0, 0, 0);
        step("sim_frz2", 1, 1, 1, 1, EnNone, 0, 0, 2'd2, 0, 0, 1, 0);
        step("sim_redir0", 1, 0, 1, 0, EnAll, 1, 1, 2'd2, 0, 0, 2, 0);
        step("sim_redir1", 1, 0, 0, 0, EnAll, 1, 0, 2'd1, 0, 1, 2, 0);
        step("sim_run", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 0, 1, 2, 0);

        // Freeze during the redirect tail
        do_reset("reset2");
        step("fr_redir0", 1, 0, 1, 0, EnAll, 1, 1, 2'd0, 0, 0, 0, 0);
        step("fr_busy1", 1, 0, 0, 1, EnNone, 0, 0, 2'd1, 0, 1, 0, 0);
        step("fr_busy2", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 1, 1, 0);
        step("fr_busy3", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 1, 2, 0);
        step("fr_tail", 1, 0, 0, 0, EnAll, 1, 0, 2'd2, 0, 1, 3, 0);
        step("fr_run", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 0, 1, 3, 0);

        // Watchdog: 3 busy, 1 idle, 4 busy; freeze counter saturates at 7
        do_reset("reset3");
        step("wd_a1", 1, 0, 0, 1, EnNone, 0, 0, 2'd0, 0, 0, 0, 0);
        step("wd_a2", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 1, 0);
        step("wd_a3", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 2, 0);
        step("wd_gap", 1, 0, 0, 0, EnAll, 0, 0, 2'd2, 0, 0, 3, 0);
        step("wd_b1", 1, 0, 0, 1, EnNone, 0, 0, 2'd0, 0, 0, 3, 0);
        step("wd_b2", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 4, 0);
        step("wd_b3", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 5, 0);
        step("wd_b4", 1, 0, 0, 1, EnNone, 0, 0, 2'd2, 0, 0, 6, 0);
        step("wd_set", 1, 0, 0, 0, EnAll, 0, 0, 2'd2, 0, 0, 7, 1);
        step("wd_sticky", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 0, 0, 7, 1);
        step("frz_sat_busy", 1, 0, 0, 1, EnNone, 0, 0, 2'd0, 0, 0, 7, 1);
        step("frz_sat", 1, 0, 0, 0, EnAll, 0, 0, 2'd2, 0, 0, 7, 1);

        // Load-use out of FREEZE, then stall counter saturation
        do_reset("reset4");
        step("lu_busy", 1, 1, 0, 1, EnNone, 0, 0, 2'd0, 0, 0, 0, 0);
        step("lu_frz_exit", 1, 1, 0, 0, EnLu, 0, 1, 2'd2, 0, 0, 1, 0);
        for (int i = 1; i < 10; i++) begin
            step("stall_sat", 1, 1, 0, 0, EnLu, 0, 1, 2'd0, (i > 7) ? 7 : i, 0, 1, 0);
        end
        step("stall_sat_idle", 1, 0, 0, 0, EnAll, 0, 0, 2'd0, 7, 0, 1, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_seq.md
Name: pipe_ctrl_seq

Overview:
- Pipeline control sequencer for the 5-stage core.
- Consumes the hazard unit's stall/flush requests and the data-memory busy signal.
- Drives per-stage register enables and flushes. Adds a second fetch-flush cycle after a redirect, because instruction memory reads take 1 cycle (synchronous).
- Keeps saturating performance counters and a sticky memory-timeout watchdog.

Parameters:
- CNT_W, 32, width of each performance counter.
- TIMEOUT, 64, consecutive mem_busy_i cycles before mem_timeout_o sets; legal range 1..2^16-1.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- stall_i  in  1  load-use stall request from the hazard unit.
- flush_i  in  1  branch/jump redirect resolved in Execute.
- mem_busy_i  in  1  data memory not ready; the whole pipeline must freeze.
- en_f_o  out  1  PC/fetch register enable.
- en_d_o  out  1  IF/ID register enable.
- en_e_o  out  1  ID/EX register enable.
- en_m_o  out  1  EX/MEM register enable.
- en_w_o  out  1  MEM/WB register enable.
- flush_d_o  out  1  clear IF/ID to a bubble.
- flush_e_o  out  1  clear ID/EX to a bubble.
- state_o  out  2  current state: 0 RUN, 1 REDIRECT, 2 FREEZE.
- stall_cycles_o  out  CNT_W  cycles in which a load-use stall was applied.
- flush_events_o  out  CNT_W  accepted redirects.
- freeze_cycles_o  out  CNT_W  cycles frozen by mem_busy_i.
- mem_timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst_n=0, acts immediately):
  - State goes to RUN; pend_redir, all counters, the busy counter and mem_timeout_o go to 0.
  - While rst_n=0: all enables 0, flush_d_o=1, flush_e_o=1, state_o=0.
- Control outputs are combinational from the current state and inputs (0-cycle latency). Counters and state update on the clock edge.
- Priority each cycle: mem_busy_i > flush_i > REDIRECT tail > stall_i > normal.
- Freeze (mem_busy_i=1, any state):
  - All enables 0; flush_d_o=0, flush_e_o=0.
  - Next state FREEZE; freeze_cycles increments.
  - If the current state is REDIRECT, pend_redir is set to 1.
  - flush_i and stall_i are ignored and not counted.
- Redirect (mem_busy_i=0, flush_i=1):
  - All enables 1; flush_d_o=1, flush_e_o=1.
  - Next state REDIRECT; flush_events increments.
  - stall_i is ignored.
- REDIRECT tail (state REDIRECT, no busy, no flush):
  - All enables 1; flush_d_o=1, flush_e_o=0.
  - Next state RUN.
  - stall_i is ignored and not counted.
- Load-use (state RUN or FREEZE-exit, no busy, no flush, stall_i=1):
  - en_f_o=0, en_d_o=0, en_e_o=1, en_m_o=1, en_w_o=1.
  - flush_e_o=1, flush_d_o=0.
  - stall_cycles increments; next state RUN.
- Normal: all enables 1, no flush, next state RUN.
- FREEZE exit (mem_busy_i=0 while in FREEZE):
  - If pend_redir=1 and flush_i=0: behave as the REDIRECT tail this cycle, clear pend_redir, next state RUN.
  - Otherwise apply the priority list above from the inputs; pend_redir clears.
- Watchdog:
  - busy_run counts consecutive mem_busy_i=1 cycles, saturating at TIMEOUT; it clears to 0 on any mem_busy_i=0 cycle.
  - mem_timeout_o sets when busy_run reaches TIMEOUT, i.e. registered on the edge ending the TIMEOUT-th busy cycle.
  - mem_timeout_o stays 1 until rst_n=0.
- Counters saturate at 2^CNT_W-1 with no wrap.
- state_o value 3 is unreachable; if it is ever entered, the next state is RUN.

Test Plan:
- Reset mid-freeze: mem_busy_i=1 for 5 cycles, then rst_n=0 → enables 0, flushes 1, state_o=0, freeze_cycles_o=0; after release with no requests, all enables 1.
- Load-use: stall_i=1 for 1 cycle in RUN → en_f_o=en_d_o=0, flush_e_o=1 that cycle; stall_cycles_o=1; next cycle all enables 1.
- Redirect: flush_i=1 for 1 cycle → cycle 0 flush_d_o=flush_e_o=1, cycle 1 flush_d_o=1 only (state_o=1), cycle 2 state_o=0; flush_events_o=1.
- Simultaneous events: flush_i=1, stall_i=1 and mem_busy_i=1 for 2 cycles, then flush_i=1 alone → 2 frozen cycles (freeze_cycles_o=2, flush_events_o=0), then redirect sequence, flush_events_o=1, stall_cycles_o=0.
- Freeze inside REDIRECT: flush_i pulse, then mem_busy_i=1 for 3 cycles during the tail → enables 0 for 3 cycles; on release one cycle with flush_d_o=1, flush_e_o=0; then RUN.
- Watchdog with TIMEOUT=4: mem_busy_i=1 for 3 cycles, 0 for 1, then 1 for 4 → mem_timeout_o stays 0 through the first burst, reads 1 the cycle after the 4th consecutive busy, stays 1 after mem_busy_i drops.
